// File: rtl/logo_motion_ctrl.sv
// Per-frame motion scheduler for the bouncing logo: X step, Y step, then commit.
// Optional button debounce enabled by defining LOGO_MOTION_DEBOUNCE_EN.
module logo_motion_ctrl #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned LOGO_W   = 64,
  parameter int unsigned LOGO_H   = 32,
  parameter int unsigned VEL_INIT = 1,
  parameter int unsigned VEL_MAX  = 7,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0,
  parameter int unsigned DEB_BITS = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       frame_start,
  input  logic       inc_vel,
  input  logic       dec_vel,
  output logic [9:0] x_logo,
  output logic [9:0] y_logo,
  output logic [2:0] vel,
  output logic       pos_valid,
  output logic       bounce
);

  localparam int unsigned POS_W   = 10;
  localparam int unsigned VEL_W   = 3;
  localparam int unsigned ARITH_W = 11;
  localparam int unsigned XMAX    = H_ACTIVE - LOGO_W;
  localparam int unsigned YMAX    = V_ACTIVE - LOGO_H;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_MOVE_X = 2'd1;
  localparam logic [1:0] S_MOVE_Y = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  if (VEL_MAX > 7 || VEL_INIT > VEL_MAX || DEB_BITS == 0) begin : g_bad_params
    $error("logo_motion_ctrl: illegal parameter set");
  end

  logic [1:0]       state, state_nxt;
  logic [POS_W-1:0] xs, ys;
  logic             dx, dy, hit;
  logic [VEL_W-1:0] v_s;

  // Button synchronizers; bit [1] is the synchronized level
  logic [1:0] inc_sync, dec_sync;
  logic       inc_lvl, dec_lvl, inc_prev, dec_prev, inc_rise, dec_rise;

  always_ff @(posedge clk) begin
    if (clr) begin
      inc_sync <= '0;
      dec_sync <= '0;
    end else begin
      inc_sync <= {inc_sync[0], inc_vel};
      dec_sync <= {dec_sync[0], dec_vel};
    end
  end

`ifdef LOGO_MOTION_DEBOUNCE_EN
  // Level only follows the synchronized input after 2^DEB_BITS stable cycles
  logic [DEB_BITS-1:0] inc_cnt, dec_cnt;
  logic                inc_deb, dec_deb;

  always_ff @(posedge clk) begin
    if (clr) begin
      inc_cnt <= '0;
      dec_cnt <= '0;
      inc_deb <= 1'b0;
      dec_deb <= 1'b0;
    end else begin
      if (inc_sync[1] == inc_deb) begin
        inc_cnt <= '0;
      end else if (&inc_cnt) begin
        inc_deb <= inc_sync[1];
        inc_cnt <= '0;
      end else begin
        inc_cnt <= inc_cnt + DEB_BITS'(1);
      end
      if (dec_sync[1] == dec_deb) begin
        dec_cnt <= '0;
      end else if (&dec_cnt) begin
        dec_deb <= dec_sync[1];
        dec_cnt <= '0;
      end else begin
        dec_cnt <= dec_cnt + DEB_BITS'(1);
      end
    end
  end

  assign inc_lvl = inc_deb;
  assign dec_lvl = dec_deb;
`else
  assign inc_lvl = inc_sync[1];
  assign dec_lvl = dec_sync[1];
`endif

  assign inc_rise = inc_lvl & ~inc_prev;
  assign dec_rise = dec_lvl & ~dec_prev;

  // Saturating velocity; simultaneous edges cancel
  always_ff @(posedge clk) begin
    if (clr) begin
      inc_prev <= 1'b0;
      dec_prev <= 1'b0;
      vel      <= VEL_W'(VEL_INIT);
    end else begin
      inc_prev <= inc_lvl;
      dec_prev <= dec_lvl;
      if (inc_rise && !dec_rise && vel < VEL_W'(VEL_MAX)) begin
        vel <= vel + VEL_W'(1);
      end else if (dec_rise && !inc_rise && vel != '0) begin
        vel <= vel - VEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (frame_start) state_nxt = S_MOVE_X;
      S_MOVE_X: state_nxt = S_MOVE_Y;
      S_MOVE_Y: state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // One axis step, shared by MOVE_X (live vel) and MOVE_Y (snapshot v_s)
  logic [POS_W-1:0]   ax_pos, ax_lim, step_pos;
  logic [VEL_W-1:0]   ax_vel;
  logic [ARITH_W-1:0] sum;
  logic               ax_dir, step_dir, step_hit;

  always_comb begin
    ax_pos = xs;
    ax_dir = dx;
    ax_lim = POS_W'(XMAX);
    ax_vel = vel;
    if (state == S_MOVE_Y) begin
      ax_pos = ys;
      ax_dir = dy;
      ax_lim = POS_W'(YMAX);
      ax_vel = v_s;
    end
    sum      = ARITH_W'(ax_pos) + ARITH_W'(ax_vel);
    step_pos = ax_pos;
    step_dir = ax_dir;
    step_hit = 1'b0;
    if (!ax_dir) begin
      if (sum >= ARITH_W'(ax_lim)) begin
        step_pos = ax_lim;
        step_dir = 1'b1;
        step_hit = 1'b1;
      end else begin
        step_pos = POS_W'(sum);
      end
    end else begin
      if (ARITH_W'(ax_pos) <= ARITH_W'(ax_vel)) begin
        step_pos = '0;
        step_dir = 1'b0;
        step_hit = 1'b1;
      end else begin
        step_pos = ax_pos - POS_W'(ax_vel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      xs        <= POS_W'(X_INIT);
      ys        <= POS_W'(Y_INIT);
      dx        <= 1'b0;
      dy        <= 1'b0;
      hit       <= 1'b0;
      v_s       <= VEL_W'(VEL_INIT);
      x_logo    <= POS_W'(X_INIT);
      y_logo    <= POS_W'(Y_INIT);
      pos_valid <= 1'b1;
      bounce    <= 1'b0;
    end else begin
      pos_valid <= (state_nxt == S_IDLE);
      bounce    <= 1'b0;
      case (state)
        S_MOVE_X: begin
          v_s <= vel;
          xs  <= step_pos;
          dx  <= step_dir;
          hit <= hit | step_hit;
        end
        S_MOVE_Y: begin
          ys  <= step_pos;
          dy  <= step_dir;
          hit <= hit | step_hit;
        end
        S_COMMIT: begin
          x_logo <= xs;
          y_logo <= ys;
          bounce <= hit;
          hit    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logo_motion_ctrl.sv
// Scoreboard bench for logo_motion_ctrl: behavioural motion model, per-scenario tasks.
module tb_logo_motion_ctrl;

  logic       clk = 1'b0;
  logic       clr, frame_start, inc_vel, dec_vel;
  logic [9:0] x_logo, y_logo;
  logic [2:0] vel;
  logic       pos_valid, bounce;

`ifdef LOGO_MOTION_DEBOUNCE_EN
  localparam int  HOLD      = 24;
  localparam bit  LAT_CHECK = 1'b0;
`else
  localparam int  HOLD      = 6;
  localparam bit  LAT_CHECK = 1'b1;
`endif
  localparam int XMAX_M = 576;
  localparam int YMAX_M = 448;

  always #5 clk = ~clk;

  logo_motion_ctrl #(.DEB_BITS(4)) dut (
    .clk(clk), .clr(clr), .frame_start(frame_start), .inc_vel(inc_vel), .dec_vel(dec_vel),
    .x_logo(x_logo), .y_logo(y_logo), .vel(vel), .pos_valid(pos_valid), .bounce(bounce)
  );

  typedef struct { int x; int y; bit b; } exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mx, my, mdx, mdy, mvel;

  function automatic void model_reset();
    mx = 0; my = 0; mdx = 0; mdy = 0; mvel = 1;
    sb.delete();
  endfunction

  function automatic void axis_step(inout int p, inout int d, input int v, input int lim, inout bit h);
    if (d == 0) begin
      if (p + v >= lim) begin p = lim; d = 1; h = 1'b1; end
      else p = p + v;
    end else begin
      if (p <= v) begin p = 0; d = 0; h = 1'b1; end
      else p = p - v;
    end
  endfunction

  task automatic test_reset();
    clr = 1'b1; frame_start = 1'b0; inc_vel = 1'b0; dec_vel = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (x_logo !== 10'd0) begin n_fail++; $display("FAIL reset_x: actual %0d required 0", x_logo); end
    n_checks++; if (y_logo !== 10'd0) begin n_fail++; $display("FAIL reset_y: actual %0d required 0", y_logo); end
    n_checks++; if (vel !== 3'd1) begin n_fail++; $display("FAIL reset_vel: actual %0d required 1", vel); end
    n_checks++; if (pos_valid !== 1'b1) begin n_fail++; $display("FAIL reset_pos_valid: actual %0b required 1", pos_valid); end
    n_checks++; if (bounce !== 1'b0) begin n_fail++; $display("FAIL reset_bounce: actual %0b required 0", bounce); end
  endtask

  // One frame; extra=1 adds an ignored second frame_start in cycle n+2
  task automatic run_frame(input bit extra);
    exp_t e;
    bit   h;
    bit   seen;
    int   lows;
    int   lows2;
    h = 1'b0; seen = 1'b0; lows = 0; lows2 = 0;
    axis_step(mx, mdx, mvel, XMAX_M, h);
    axis_step(my, mdy, mvel, YMAX_M, h);
    e.x = mx; e.y = my; e.b = h;
    sb.push_back(e);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (extra && i == 1) frame_start = 1'b1;
      if (extra && i == 2) frame_start = 1'b0;
      if (pos_valid === 1'b0) lows++;
      else begin seen = 1'b1; break; end
      @(negedge clk);
    end
    frame_start = 1'b0;
    n_checks++; if (!seen) begin n_fail++; $display("FAIL frame_timeout: actual no commit required commit within 10 cycles"); end
    if (seen) begin
      e = sb.pop_front();
      n_checks++; if (x_logo !== 10'(e.x)) begin n_fail++; $display("FAIL frame_x: actual %0d required %0d", x_logo, e.x); end
      n_checks++; if (y_logo !== 10'(e.y)) begin n_fail++; $display("FAIL frame_y: actual %0d required %0d", y_logo, e.y); end
      n_checks++; if (bounce !== e.b) begin n_fail++; $display("FAIL frame_bounce: actual %0b required %0b", bounce, e.b); end
      n_checks++; if (lows != 3) begin n_fail++; $display("FAIL pos_valid_low_cycles: actual %0d required 3", lows); end
      @(negedge clk);
      n_checks++; if (bounce !== 1'b0) begin n_fail++; $display("FAIL bounce_width: actual %0b required 0", bounce); end
      if (extra) begin
        for (int i = 0; i < 6; i++) begin
          if (pos_valid !== 1'b1) lows2++;
          @(negedge clk);
        end
        n_checks++; if (lows2 != 0) begin n_fail++; $display("FAIL ignored_frame_start: actual %0d low cycles required 0", lows2); end
        n_checks++; if (x_logo !== 10'(e.x)) begin n_fail++; $display("FAIL ignored_frame_x: actual %0d required %0d", x_logo, e.x); end
      end
    end
  endtask

  task automatic press(input bit i, input bit d, input bit lat);
    int old_v;
    old_v = mvel;
    if (i && !d && mvel < 7) mvel++;
    else if (d && !i && mvel > 0) mvel--;
    @(negedge clk);
    inc_vel = i; dec_vel = d;
    if (lat) begin
      repeat (2) @(negedge clk);
      n_checks++; if (vel !== 3'(old_v)) begin n_fail++; $display("FAIL vel_early: actual %0d required %0d", vel, old_v); end
      @(negedge clk);
      n_checks++; if (vel !== 3'(mvel)) begin n_fail++; $display("FAIL vel_latency: actual %0d required %0d", vel, mvel); end
    end
    repeat (HOLD) @(negedge clk);
    inc_vel = 1'b0; dec_vel = 1'b0;
    repeat (HOLD) @(negedge clk);
    n_checks++; if (vel !== 3'(mvel)) begin n_fail++; $display("FAIL vel_press: actual %0d required %0d", vel, mvel); end
  endtask

  task automatic test_first_frame();
    run_frame(1'b0);
    n_checks++; if (x_logo !== 10'd1 || y_logo !== 10'd1) begin n_fail++; $display("FAIL first_frame_pos: actual %0d,%0d required 1,1", x_logo, y_logo); end
  endtask

  task automatic test_velocity();
    for (int k = 0; k < 3; k++) press(1'b1, 1'b0, LAT_CHECK && k == 0);
    n_checks++; if (vel !== 3'd4) begin n_fail++; $display("FAIL vel_after_3_inc: actual %0d required 4", vel); end
    for (int k = 0; k < 10; k++) press(1'b1, 1'b0, 1'b0);
    n_checks++; if (vel !== 3'd7) begin n_fail++; $display("FAIL vel_saturate: actual %0d required 7", vel); end
    for (int k = 0; k < 9; k++) press(1'b0, 1'b1, 1'b0);
    n_checks++; if (vel !== 3'd0) begin n_fail++; $display("FAIL vel_floor: actual %0d required 0", vel); end
    run_frame(1'b0);
    run_frame(1'b0);
    n_checks++; if (x_logo !== 10'd1 || y_logo !== 10'd1) begin n_fail++; $display("FAIL frozen_pos: actual %0d,%0d required 1,1", x_logo, y_logo); end
  endtask

  task automatic set_vel_max();
    for (int k = 0; k < 6; k++) press(1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_y_bounce();
    test_reset();
    set_vel_max();
    for (int k = 0; k < 64; k++) run_frame(1'b0);
    n_checks++; if (y_logo !== 10'd448) begin n_fail++; $display("FAIL y_clamp: actual %0d required 448", y_logo); end
    run_frame(1'b0);
    n_checks++; if (y_logo !== 10'd441) begin n_fail++; $display("FAIL y_reverse: actual %0d required 441", y_logo); end
  endtask

  task automatic test_x_bounce();
    test_reset();
    set_vel_max();
    for (int k = 0; k < 83; k++) run_frame(1'b0);
    n_checks++; if (x_logo !== 10'd576) begin n_fail++; $display("FAIL x_clamp: actual %0d required 576", x_logo); end
    run_frame(1'b0);
    n_checks++; if (x_logo !== 10'd569) begin n_fail++; $display("FAIL x_reverse: actual %0d required 569", x_logo); end
  endtask

  task automatic test_back_to_back();
    run_frame(1'b1);
  endtask

  task automatic test_clr_abort();
    int lows;
    lows = 0;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    model_reset();
    n_checks++; if (x_logo !== 10'd0 || y_logo !== 10'd0) begin n_fail++; $display("FAIL clr_pos: actual %0d,%0d required 0,0", x_logo, y_logo); end
    n_checks++; if (vel !== 3'd1) begin n_fail++; $display("FAIL clr_vel: actual %0d required 1", vel); end
    n_checks++; if (pos_valid !== 1'b1 || bounce !== 1'b0) begin n_fail++; $display("FAIL clr_flags: actual %0b%0b required 10", pos_valid, bounce); end
    for (int i = 0; i < 6; i++) begin
      if (pos_valid !== 1'b1 || x_logo !== 10'd0) lows++;
      @(negedge clk);
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL clr_no_commit: actual %0d bad cycles required 0", lows); end
    run_frame(1'b0);
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b1, 1'b0);
    n_checks++; if (vel !== 3'd1) begin n_fail++; $display("FAIL vel_both_edges: actual %0d required 1", vel); end
  endtask

`ifdef LOGO_MOTION_DEBOUNCE_EN
  task automatic test_debounce();
    @(negedge clk) inc_vel = 1'b1;
    repeat (10) @(negedge clk);
    inc_vel = 1'b0;
    repeat (30) @(negedge clk);
    n_checks++; if (vel !== 3'(mvel)) begin n_fail++; $display("FAIL debounce_glitch: actual %0d required %0d", vel, mvel); end
    inc_vel = 1'b1;
    repeat (20) @(negedge clk);
    inc_vel = 1'b0;
    repeat (30) @(negedge clk);
    if (mvel < 7) mvel++;
    n_checks++; if (vel !== 3'(mvel)) begin n_fail++; $display("FAIL debounce_press: actual %0d required %0d", vel, mvel); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_frame();
    test_velocity();
    test_y_bounce();
    test_x_bounce();
    test_back_to_back();
    test_clr_abort();
    test_simultaneous();
`ifdef LOGO_MOTION_DEBOUNCE_EN
    test_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual time limit reached required completion");
    $fatal(1);
  end

endmodule
